load_store_unit: RTL and testbench

- Initiator side of the data-memory interface. Accepts one load/store request at a time from the core over a valid/ready handshake and drives the word-addressed memory system: address, write data and write enable out; combinational read data back.
- Adds sub-word (byte/halfword) loads with sign/zero extension and sub-word stores via read-modify-write.
- Flags misaligned accesses and stores into the read-only region below RAM_BASE.

---
 rtl/load_store_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data-memory interface. Takes one load/store request
//   at a time from the core and drives a word-addressed memory with
//   combinational read data. Sub-word stores are done as read-modify-write.
//   Misaligned accesses and stores below RAM_BASE return an error response
//   and never touch memory.
//
// Configuration macro:
//   LSU_SUBWORD_EN  defined   : LH/LHU/LB/LBU/SH/SB supported
//                   undefined : only LW/SW; every other op returns an error
//
// Ports:
//   CLK, RST_n            clock (rising edge), async active-low reset
//   req_valid_i/ready_o   request handshake
//   req_op_i              0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
//   req_addr_i            byte address
//   req_wdata_i           store data (low bits used for SH/SB)
//   resp_valid_o/ready_i  response handshake
//   resp_rdata_o          extended load result, 0 for stores and errors
//   resp_error_o          misaligned access or store into read-only region
//   Mem_Address_o         word-aligned address to memory
//   Mem_Write_Data_o      word to write
//   Mem_Write_Enable_o    one-cycle write strobe
//   Mem_Read_Data_i       combinational read data for Mem_Address_o
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_error_o,
  output logic [31:0]           Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  output logic                  Mem_Write_Enable_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;

`ifdef LSU_SUBWORD_EN
  // Only the lane offset and the low half of the store data are needed
  // after accept; the word address lives in mem_addr_q.
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;

  function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'h0000, h};
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'h000000, b};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wd,
                                              input logic [31:0] word);
    logic [31:0] m;
    m = word;
    if (op == OP_SB) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    store_merge = m;
  endfunction
`endif

  // Request classification, evaluated on the incoming request in IDLE.
  logic is_load, is_store, is_word, is_half, req_err;

  always_comb begin
    is_store = (req_op_i == OP_SW) || (req_op_i == OP_SH) || (req_op_i == OP_SB);
    is_load  = !is_store;
    is_word  = (req_op_i == OP_LW) || (req_op_i == OP_SW);
    is_half  = (req_op_i == OP_LH) || (req_op_i == OP_LHU) || (req_op_i == OP_SH);
    req_err  = (is_word && (req_addr_i[1:0] != 2'b00))
             || (is_half && req_addr_i[0])
             || (is_store && (req_addr_i < RAM_BASE));
`ifndef LSU_SUBWORD_EN
    req_err  = req_err || !is_word;
`endif
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
`ifdef LSU_SUBWORD_EN
    op_d         = op_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
`ifdef LSU_SUBWORD_EN
          op_d    = req_op_i;
          lane_d  = req_addr_i[1:0];
          wdata_d = req_wdata_i[15:0];
`endif
          resp_rdata_d = '0;
          if (req_err) begin
            resp_error_d = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            resp_error_d = 1'b0;
            mem_addr_d   = {req_addr_i[31:2], 2'b00};
            if (is_load) begin
              state_d = RD;
            end else if (req_op_i == OP_SW) begin
              mem_wdata_d = req_wdata_i;
              mem_we_d    = 1'b1;
              state_d     = WR;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      RD: begin
`ifdef LSU_SUBWORD_EN
        resp_rdata_d = load_extend(op_q, lane_q, Mem_Read_Data_i);
`else
        resp_rdata_d = Mem_Read_Data_i;
`endif
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
`ifdef LSU_SUBWORD_EN
      RMW_RD: begin
        mem_wdata_d = store_merge(op_q, lane_q, wdata_q, Mem_Read_Data_i);
        mem_we_d    = 1'b1;
        state_d     = WR;
      end
`endif
      WR: begin
        resp_rdata_d = '0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
`ifdef LSU_SUBWORD_EN
      op_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
`ifdef LSU_SUBWORD_EN
      op_q         <= op_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
`endif
    end
  end

  // Gated with RST_n so ready reads 0 while reset is held.
  assign req_ready_o        = (state_q == IDLE) && RST_n;
  assign resp_valid_o       = resp_valid_q;
  assign resp_rdata_o       = resp_rdata_q;
  assign resp_error_o       = resp_error_q;
  assign Mem_Address_o      = mem_addr_q;
  assign Mem_Write_Data_o   = mem_wdata_q;
  assign Mem_Write_Enable_o = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = 3'd0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_error_o;
  logic [31:0] Mem_Address_o;
  logic [31:0] Mem_Write_Data_o;
  logic        Mem_Write_Enable_o;
  logic [31:0] Mem_Read_Data_i;

  load_store_unit dut (
    .CLK               (CLK),
    .RST_n             (RST_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_addr_i        (req_addr_i),
    .req_wdata_i       (req_wdata_i),
    .resp_valid_o      (resp_valid_o),
    .resp_ready_i      (resp_ready_i),
    .resp_rdata_o      (resp_rdata_o),
    .resp_error_o      (resp_error_o),
    .Mem_Address_o     (Mem_Address_o),
    .Mem_Write_Data_o  (Mem_Write_Data_o),
    .Mem_Write_Enable_o(Mem_Write_Enable_o),
    .Mem_Read_Data_i   (Mem_Read_Data_i)
  );

  always #5 CLK = ~CLK;

  // Small word memory at RAM_BASE; preload and DUT writes share one process.
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'h0;
  int          strobe_cnt = 0;
  logic [31:0] we_addr = 32'h0;
  logic [31:0] we_data = 32'h0;

  assign Mem_Read_Data_i = mem[Mem_Address_o[7:2]];

  always @(posedge CLK) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (Mem_Write_Enable_o) begin
      mem[Mem_Address_o[7:2]] <= Mem_Write_Data_o;
      strobe_cnt <= strobe_cnt + 1;
      we_addr    <= Mem_Address_o;
      we_data    <= Mem_Write_Data_o;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge CLK);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge CLK);
    pre_en  = 1'b0;
  endtask

  // Issue one request, measure edges from accept (inclusive) to resp_valid.
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_strobes);
    int lat;
    int s0;
    @(negedge CLK);
    check({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    s0 = strobe_cnt;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    req_valid_i = 1'b0;
    while (!resp_valid_o && lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    check({tag, "_valid"}, {31'b0, resp_valid_o}, 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, resp_rdata_o, exp_rd);
    check({tag, "_err"}, {31'b0, resp_error_o}, {31'b0, exp_err});
    resp_ready_i = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready_i = 1'b0;
    check({tag, "_strobes"}, strobe_cnt - s0, exp_strobes);
  endtask

  initial begin
    int n;
    // ---------------- reset state ----------------
    #12;
    check("rst_ready", {31'b0, req_ready_o}, 32'd0);
    check("rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_we", {31'b0, Mem_Write_Enable_o}, 32'd0);
    check("rst_addr", Mem_Address_o, 32'h0);
    check("rst_rdata", resp_rdata_o, 32'h0);
    check("rst_error", {31'b0, resp_error_o}, 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    #1;
    check("rst_ready_after", {31'b0, req_ready_o}, 32'd1);

    // ---------------- word load ----------------
    preload(6'd1, 32'hDEAD_BEEF);
    run("lw", OP_LW, 32'h1001_0004, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 0);

    // ---------------- sub-word loads/stores ----------------
    preload(6'd1, 32'h8011_2233);
    preload(6'd2, 32'h1122_3344);
`ifdef LSU_SUBWORD_EN
    run("lb",  OP_LB,  32'h1001_0007, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 0);
    run("lbu", OP_LBU, 32'h1001_0007, 32'h0, 2, 32'h0000_0080, 1'b0, 0);
    run("lhu", OP_LHU, 32'h1001_0006, 32'h0, 2, 32'h0000_8011, 1'b0, 0);
    run("lh",  OP_LH,  32'h1001_0006, 32'h0, 2, 32'hFFFF_8011, 1'b0, 0);
    run("lb0", OP_LB,  32'h1001_0004, 32'h0, 2, 32'h0000_0033, 1'b0, 0);
    run("sb",  OP_SB,  32'h1001_0009, 32'h0000_00AB, 3, 32'h0, 1'b0, 1);
    check("sb_addr", we_addr, 32'h1001_0008);
    check("sb_data", we_data, 32'h1122_AB44);
    run("sb_rb", OP_LW, 32'h1001_0008, 32'h0, 2, 32'h1122_AB44, 1'b0, 0);
    run("sh",  OP_SH,  32'h1001_000A, 32'h5555_BEEF, 3, 32'h0, 1'b0, 1);
    check("sh_data", we_data, 32'hBEEF_AB44);
    run("lh_rb", OP_LH, 32'h1001_000A, 32'h0, 2, 32'hFFFF_BEEF, 1'b0, 0);
    run("lh_mis", OP_LH, 32'h1001_0005, 32'h0, 1, 32'h0, 1'b1, 0);
`else
    run("lb_dis",  OP_LB,  32'h1001_0007, 32'h0, 1, 32'h0, 1'b1, 0);
    run("lbu_dis", OP_LBU, 32'h1001_0007, 32'h0, 1, 32'h0, 1'b1, 0);
    run("lhu_dis", OP_LHU, 32'h1001_0006, 32'h0, 1, 32'h0, 1'b1, 0);
    run("sb_dis",  OP_SB,  32'h1001_0009, 32'h0000_00AB, 1, 32'h0, 1'b1, 0);
    run("sh_dis",  OP_SH,  32'h1001_000A, 32'h0000_BEEF, 1, 32'h0, 1'b1, 0);
    run("sb_rb", OP_LW, 32'h1001_0008, 32'h0, 2, 32'h1122_3344, 1'b0, 0);
`endif

    // ---------------- word store and error cases ----------------
    run("sw", OP_SW, 32'h1001_0010, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1);
    check("sw_addr", we_addr, 32'h1001_0010);
    check("sw_data", we_data, 32'hCAFE_F00D);
    run("sw_rb", OP_LW, 32'h1001_0010, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0);
    run("sw_ro",  OP_SW, 32'h0040_0000, 32'h1234_5678, 1, 32'h0, 1'b1, 0);
    run("lw_mis", OP_LW, 32'h1001_0002, 32'h0, 1, 32'h0, 1'b1, 0);
    run("sw_mis", OP_SW, 32'h1001_0011, 32'h1, 1, 32'h0, 1'b1, 0);
    run("sb_ro",  OP_SB, 32'h0040_0003, 32'h1, 1, 32'h0, 1'b1, 0);
    run("lw_ro_ok", OP_LW, 32'h1001_0000, 32'h0, 2, 32'hxxxx_xxxx, 1'b0, 0);

    // ---------------- response stall and back-to-back ----------------
    preload(6'd3, 32'h1357_2468);
    preload(6'd1, 32'h2468_ACE0);
    @(negedge CLK);
    req_valid_i = 1'b1;
    req_op_i    = OP_LW;
    req_addr_i  = 32'h1001_000C;
    @(posedge CLK);
    @(negedge CLK);
    req_addr_i  = 32'h1001_0004;   // second request waits behind the first
    check("stall_busy_ready", {31'b0, req_ready_o}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, resp_valid_o}, 32'd1);
      check("stall_rdata", resp_rdata_o, 32'h1357_2468);
      check("stall_ready", {31'b0, req_ready_o}, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
    end
    resp_ready_i = 1'b1;
    check("consume_ready", {31'b0, req_ready_o}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    resp_ready_i = 1'b0;
    check("b2b_idle_ready", {31'b0, req_ready_o}, 32'd1);
    check("b2b_idle_valid", {31'b0, resp_valid_o}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    req_valid_i = 1'b0;
    check("b2b_busy_ready", {31'b0, req_ready_o}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("b2b_valid", {31'b0, resp_valid_o}, 32'd1);
    check("b2b_rdata", resp_rdata_o, 32'h2468_ACE0);
    resp_ready_i = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    resp_ready_i = 1'b0;
    check("b2b_done_valid", {31'b0, resp_valid_o}, 32'd0);

    // ---------------- reset during the write cycle ----------------
    preload(6'd0, 32'h5555_5555);
    @(negedge CLK);
    n = strobe_cnt;
    req_valid_i = 1'b1;
`ifdef LSU_SUBWORD_EN
    req_op_i    = OP_SH;
    req_addr_i  = 32'h1001_0002;
    req_wdata_i = 32'h0000_1234;
`else
    req_op_i    = OP_SW;
    req_addr_i  = 32'h1001_0000;
    req_wdata_i = 32'h1234_5678;
`endif
    @(posedge CLK);
    @(negedge CLK);
    req_valid_i = 1'b0;
    for (int i = 0; i < 5 && !Mem_Write_Enable_o; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("wr_we_seen", {31'b0, Mem_Write_Enable_o}, 32'd1);
    #1;
    RST_n = 1'b0;
    #1;
    check("rstwr_we", {31'b0, Mem_Write_Enable_o}, 32'd0);
    check("rstwr_addr", Mem_Address_o, 32'h0);
    check("rstwr_wdata", Mem_Write_Data_o, 32'h0);
    check("rstwr_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rstwr_ready", {31'b0, req_ready_o}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    #1;
    check("rstwr_ready_after", {31'b0, req_ready_o}, 32'd1);
    check("rstwr_no_strobe", strobe_cnt - n, 32'd0);
    run("post_rst_lw", OP_LW, 32'h1001_0000, 32'h0, 2, 32'h5555_5555, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
